// File: rtl/elink_tx_arbiter_if.sv
// Transaction bundle shared by the three bridge sources, the tx arbiter and the eLink framer.
// Request buses are packed {src2,src1,src0}.
interface elink_tx_arbiter_if;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_stream;
    logic [2:0]  req_write;
    logic [5:0]  req_datamode;
    logic [11:0] req_ctrlmode;
    logic [95:0] req_dstaddr;
    logic [95:0] req_srcaddr;
    logic [95:0] req_data;

    logic        tx_valid;
    logic        tx_ready;
    logic        tx_write;
    logic [1:0]  tx_datamode;
    logic [3:0]  tx_ctrlmode;
    logic [31:0] tx_dstaddr;
    logic [31:0] tx_srcaddr;
    logic [31:0] tx_data;
    logic        tx_stream;
    logic        tx_wr_wait;
    logic        tx_rd_wait;
    logic [2:0]  grant;

    modport slave (
        input  req_valid, req_stream, req_write, req_datamode, req_ctrlmode,
               req_dstaddr, req_srcaddr, req_data,
               tx_ready, tx_wr_wait, tx_rd_wait,
        output req_ready,
               tx_valid, tx_write, tx_datamode, tx_ctrlmode,
               tx_dstaddr, tx_srcaddr, tx_data, tx_stream, grant
    );

    modport master (
        output req_valid, req_stream, req_write, req_datamode, req_ctrlmode,
               req_dstaddr, req_srcaddr, req_data,
               tx_ready, tx_wr_wait, tx_rd_wait,
        input  req_ready,
               tx_valid, tx_write, tx_datamode, tx_ctrlmode,
               tx_dstaddr, tx_srcaddr, tx_data, tx_stream, grant
    );
endinterface

// File: rtl/elink_tx_arbiter.sv
// Round-robin, wait-gated three-source arbiter onto the eLink tx port with stream locking.
// States: ST_IDLE = round-robin search | ST_LOCKED = only r_owner may be accepted.
module elink_tx_arbiter #(
    parameter int unsigned MAX_STREAM = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    elink_tx_arbiter_if.slave bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic [7:0] MAX_CNT   = 8'(MAX_STREAM);

    function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    logic [0:0]  r_state;
    logic [1:0]  r_owner;
    logic [1:0]  r_rr_ptr;
    logic [7:0]  r_beat_cnt;

    logic        r_tx_valid;
    logic        r_tx_write;
    logic        r_tx_stream;
    logic [1:0]  r_tx_datamode;
    logic [3:0]  r_tx_ctrlmode;
    logic [31:0] r_tx_dstaddr;
    logic [31:0] r_tx_srcaddr;
    logic [31:0] r_tx_data;
    logic [2:0]  r_grant;

    logic [2:0]  w_elig;
    logic        w_slot_free;
    logic        w_accept;
    logic [1:0]  w_sel;
    logic [2:0]  w_sel_oh;
    logic        w_stream_sel;
    logic [7:0]  w_cnt_inc;
    logic        w_release;
    logic        w_abandon;

    always_comb begin
        w_elig = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_elig[i] = bus.req_valid[i] & ~(bus.req_write[i] ? bus.tx_wr_wait : bus.tx_rd_wait);
        end
    end

    assign w_slot_free = ~r_tx_valid | bus.tx_ready;

    always_comb begin
        w_accept = 1'b0;
        w_sel    = 2'd0;
        if (aresetn && w_slot_free) begin
            if (r_state == ST_LOCKED) begin
                if (w_elig[r_owner]) begin
                    w_accept = 1'b1;
                    w_sel    = r_owner;
                end
            end else begin
                // Scan from the far end so the candidate nearest rr_ptr overrides.
                for (int k = 2; k >= 0; k--) begin
                    if (w_elig[wrap3(r_rr_ptr, 2'(k))]) begin
                        w_accept = 1'b1;
                        w_sel    = wrap3(r_rr_ptr, 2'(k));
                    end
                end
            end
        end
    end

    assign w_sel_oh     = w_accept ? (3'b001 << w_sel) : 3'b000;
    assign w_stream_sel = bus.req_stream[w_sel];
    assign w_cnt_inc    = (r_beat_cnt >= MAX_CNT) ? MAX_CNT : r_beat_cnt + 8'd1;
    assign w_release    = (r_state == ST_LOCKED) & (~w_stream_sel | (w_cnt_inc >= MAX_CNT));
    assign w_abandon    = (r_state == ST_LOCKED) & ~w_accept & w_slot_free & ~bus.req_valid[r_owner];

    assign bus.req_ready = w_sel_oh;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_owner    <= 2'd0;
            r_rr_ptr   <= 2'd0;
            r_beat_cnt <= 8'd0;
        end else if (w_accept) begin
            r_rr_ptr <= wrap3(w_sel, 2'd1);
            if (r_state == ST_IDLE) begin
                if (w_stream_sel) begin
                    r_state    <= ST_LOCKED;
                    r_owner    <= w_sel;
                    r_beat_cnt <= 8'd1;
                end
            end else if (w_release) begin
                r_state    <= ST_IDLE;
                r_beat_cnt <= 8'd0;
            end else begin
                r_beat_cnt <= w_cnt_inc;
            end
        end else if (w_abandon) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= 8'd0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tx_valid    <= 1'b0;
            r_tx_write    <= 1'b0;
            r_tx_stream   <= 1'b0;
            r_tx_datamode <= 2'd0;
            r_tx_ctrlmode <= 4'd0;
            r_tx_dstaddr  <= 32'd0;
            r_tx_srcaddr  <= 32'd0;
            r_tx_data     <= 32'd0;
            r_grant       <= 3'b000;
        end else if (w_accept) begin
            r_tx_valid    <= 1'b1;
            r_tx_write    <= bus.req_write[w_sel];
            r_tx_stream   <= w_stream_sel & ~w_release;
            r_tx_datamode <= bus.req_datamode[{w_sel, 1'b0} +: 2];
            r_tx_ctrlmode <= bus.req_ctrlmode[{w_sel, 2'b00} +: 4];
            r_tx_dstaddr  <= bus.req_dstaddr[{w_sel, 5'd0} +: 32];
            r_tx_srcaddr  <= bus.req_srcaddr[{w_sel, 5'd0} +: 32];
            r_tx_data     <= bus.req_data[{w_sel, 5'd0} +: 32];
            r_grant       <= w_sel_oh;
        end else if (bus.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_grant    <= 3'b000;
        end
    end

    assign bus.tx_valid    = r_tx_valid;
    assign bus.tx_write    = r_tx_write;
    assign bus.tx_stream   = r_tx_stream;
    assign bus.tx_datamode = r_tx_datamode;
    assign bus.tx_ctrlmode = r_tx_ctrlmode;
    assign bus.tx_dstaddr  = r_tx_dstaddr;
    assign bus.tx_srcaddr  = r_tx_srcaddr;
    assign bus.tx_data     = r_tx_data;
    assign bus.grant       = r_grant;
endmodule

// File: doc/elink_tx_arbiter.md
# elink_tx_arbiter

Three-way arbiter that shares the single eLink transmit transaction port between the read-response, write and read-request sources of the elink2 stream bridge. Round-robin selection, gated by the eLink `wr_wait` / `rd_wait` back-pressure. Stream (burst) locking keeps consecutive write beats of one source contiguous on the link, so the downstream framer can emit them as one eLink stream. Output is registered, one transaction deep.

## Interface
Parameters:
- MAX_STREAM, 16: maximum beats one source may hold a stream lock (2..255).

Ports (index i = source 0..2; packed buses are {src2,src1,src0}):
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  3  source i has a transaction
- req_ready  out  3  source i transaction accepted this cycle
- req_stream  in  3  next beat from source i continues a stream
- req_write  in  3  transaction is a write
- req_datamode  in  6  2 bits per source
- req_ctrlmode  in  12  4 bits per source
- req_dstaddr, req_srcaddr, req_data  in  96 each  32 bits per source
- tx_valid  out  1  output transaction valid
- tx_ready  in  1  framer accepts output
- tx_write, tx_datamode[1:0], tx_ctrlmode[3:0], tx_dstaddr[31:0], tx_srcaddr[31:0], tx_data[31:0]  out  registered copy of the accepted transaction
- tx_stream  out  1  another beat of the same stream follows
- tx_wr_wait  in  1  eLink write back-pressure, synchronous to aclk
- tx_rd_wait  in  1  eLink read back-pressure, synchronous to aclk
- grant  out  3  one-hot owner of the last accepted beat; 0 when idle

## Operation
- Eligible(i) = req_valid[i] & ~(req_write[i] ? tx_wr_wait : tx_rd_wait).
- Slot free = ~tx_valid | tx_ready.
- States:
  - IDLE: if the slot is free, accept the first eligible source, searching from rr_ptr upward modulo 3.
  - LOCKED(owner): only the owner may be accepted.
- On acceptance of source i:
  - req_ready[i]=1 (combinational, at most one bit set).
  - Transaction fields are registered into tx_*; tx_valid=1; grant=onehot(i); rr_ptr=(i+1) mod 3.
- Transition to LOCKED(owner=i), beat count=1, when an IDLE acceptance has req_stream[i]=1.
- In LOCKED, each accepted owner beat increments the beat count.
- Exit from LOCKED to IDLE:
  - the accepted beat has req_stream=0; or
  - the beat count reaches MAX_STREAM (forced release); or
  - req_valid[owner]=0 while the slot is free (abandoned stream).
- tx_stream = req_stream of the accepted beat, forced to 0 on the forced-release beat and on any beat that exits LOCKED.
- While LOCKED with the owner stalled by a wait signal: hold LOCKED and accept nothing. Other sources stay blocked.
- Waits gate only new acceptance. A beat already in the tx_* register stays valid until tx_ready, regardless of the wait signals.
- The beat counter is 8-bit and saturates at MAX_STREAM; it never wraps.

## Timing
- Reset (async assert, release synchronous to aclk):
  - tx_valid=0, all tx_* fields=0, tx_stream=0, grant=0
  - rr_ptr=0, state IDLE, beat count=0
  - req_ready=0 during reset.
- Latency: req acceptance at edge N produces tx_valid=1 with its data after edge N (visible in cycle N+1).
- Throughput: 1 transaction/cycle when tx_ready is held high.
- tx_* fields are stable while tx_valid=1 and tx_ready=0.
- Simultaneous tx_ready and a new acceptance in the same cycle: the register is reloaded, so there is no bubble.
- grant holds its value until the next acceptance. It returns to 0 only on the cycle after tx_valid is drained with no new acceptance.
- Reset asserted mid-stream: the lock is abandoned, all state returns to its reset values, and no partial beat is emitted.

## Test plan
- Fairness: after reset, all three sources hold valid writes with stream=0 and tx_ready=1. Grant order is 0,1,2,0,1,2. One tx beat per cycle. First tx_valid appears one cycle after release.
- Wait gating: src0 read, src1 write, tx_rd_wait=1. Only src1 is accepted. After tx_rd_wait drops, src0 is accepted next cycle.
- Stream lock: src1 sends 5 beats with stream=1,1,1,1,0 while src0 and src2 are also valid. The 5 beats are contiguous, tx_stream=1,1,1,1,0, then src2 is granted.
- Forced release: MAX_STREAM=4 and src2 holds stream=1 for 10 beats. tx_stream drops on beat 4, src0 is granted next, and src2 resumes later.
- Back-pressure: tx_ready=0 for 3 cycles with tx_valid=1. tx_* stays stable and req_ready=0. On tx_ready=1 the next beat is loaded in the same cycle.
- Abandon and reset: src0 is LOCKED and deasserts valid, so it returns to IDLE and src1 is served. aresetn pulses low mid-stream, and all outputs return to 0 asynchronously.
